// File: rtl/replay_cmd_queue_pkg.sv
// Shared types for the replay command queue: FSM state encoding and the
// integration-level command word type.
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif
`ifndef Max_replay_Iter
`define Max_replay_Iter 8
`endif

package replay_cmd_queue_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    WINDOW = 1'b1
  } replay_q_state_e;

  typedef logic [`PACKET_SIZE-1:0] com_packet;

endpackage

// File: rtl/replay_cmd_queue_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port; contents are deliberately not reset.
module replay_q_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/replay_cmd_queue.sv
// FWFT command queue with a replay window: entries read inside the window stay
// held until the last iteration commits; writes are dropped while wfull.
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif
`ifndef Max_replay_Iter
`define Max_replay_Iter 8
`endif

module replay_cmd_queue
  import replay_cmd_queue_pkg::*;
#(
  parameter int DATA_W     = `PACKET_SIZE,
  parameter int DEPTH      = 16,
  parameter int MAX_REPLAY = `Max_replay_Iter,
  localparam int AW        = $clog2(DEPTH),
  localparam int PW        = AW + 1,
  localparam int IW        = (MAX_REPLAY > 1) ? $clog2(MAX_REPLAY) : 1,
  localparam int CW        = IW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              winc,
  input  logic [DATA_W-1:0] wdata,
  output logic              wfull,
  input  logic              rinc,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              win_open,
  input  logic [CW-1:0]     win_iters,
  input  logic              replay,
  output logic              in_window,
  output logic [IW-1:0]     replay_iter,
  output logic              replay_done,
  output logic [PW-1:0]     count,
  output logic              window_err
);

  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_FULL = PW'(DEPTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [IW-1:0] I_ONE  = IW'(1);

  replay_q_state_e state_q, state_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d, base_q, base_d, ws_q, ws_d;
  logic [PW-1:0]   rd_step;
  logic [CW-1:0]   iters_q, iters_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic            done_q, done_d, err_q, err_d;
  logic            wr_en, rd_adv, last_iter;

  assign count       = wr_q - base_q;
  assign wfull       = (count == P_FULL);
  assign rvalid      = (rd_q != wr_q);
  assign in_window   = (state_q == WINDOW);
  assign replay_iter = iter_q;
  assign replay_done = done_q;
  assign window_err  = err_q;

  assign wr_en     = winc && !wfull;
  assign rd_adv    = rinc && rvalid;
  assign rd_step   = rd_adv ? (rd_q + P_ONE) : rd_q;
  assign last_iter = ({1'b0, iter_q} == (iters_q - C_ONE));

  always_comb begin
    state_d = state_q;
    wr_d    = wr_en ? (wr_q + P_ONE) : wr_q;
    rd_d    = rd_q;
    base_d  = base_q;
    ws_d    = ws_q;
    iters_d = iters_q;
    iter_d  = iter_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        rd_d   = rd_step;
        base_d = rd_step;
        if (replay && !win_open) err_d = 1'b1;
        // The window starts at the pre-read pointer, so the entry being read
        // this cycle stays held rather than being freed.
        if (win_open) begin
          ws_d    = rd_q;
          base_d  = rd_q;
          iters_d = (win_iters == '0) ? C_ONE : win_iters;
          iter_d  = '0;
          state_d = WINDOW;
        end
      end
      WINDOW: begin
        base_d = ws_q;
        if (win_open) err_d = 1'b1;
        if (wfull && !rvalid) err_d = 1'b1;
        if (replay) begin
          if (last_iter) begin
            base_d  = rd_q;
            done_d  = 1'b1;
            iter_d  = '0;
            state_d = IDLE;
          end else begin
            rd_d   = ws_q;
            iter_d = iter_q + I_ONE;
          end
        end else begin
          rd_d = rd_step;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      base_q  <= '0;
      ws_q    <= '0;
      iters_q <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      base_q  <= base_d;
      ws_q    <= ws_d;
      iters_q <= iters_d;
      iter_q  <= iter_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  replay_q_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wr_q[AW-1:0]),
    .wdata_i(wdata),
    .raddr_i(rd_q[AW-1:0]),
    .rdata_o(rdata)
  );

endmodule

// File: tb/tb_replay_cmd_queue.sv
// Scoreboard bench for replay_cmd_queue at DEPTH=4.
module tb_replay_cmd_queue;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int MR    = 8;
  localparam int PW    = 3;
  localparam int IW    = 3;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset, winc, rinc, win_open, replay;
  logic [DW-1:0] wdata, rdata;
  logic [CW-1:0] win_iters;
  logic          wfull, rvalid, in_window, replay_done, window_err;
  logic [IW-1:0] replay_iter;
  logic [PW-1:0] count;

  replay_cmd_queue #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_REPLAY(MR)) dut (
    .clk(clk), .reset(reset), .winc(winc), .wdata(wdata), .wfull(wfull),
    .rinc(rinc), .rdata(rdata), .rvalid(rvalid), .win_open(win_open),
    .win_iters(win_iters), .replay(replay), .in_window(in_window),
    .replay_iter(replay_iter), .replay_done(replay_done), .count(count),
    .window_err(window_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] hist[$];
  bit in_win = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    winc = 1'b0; rinc = 1'b0; win_open = 1'b0; replay = 1'b0;
  endtask

  task automatic push_wr(input logic [DW-1:0] d, input bit accept);
    winc = 1'b1; wdata = d;
    if (accept) exp_q.push_back(d);
    tick();
  endtask

  task automatic pop_rd(input string tag);
    logic [DW-1:0] e;
    check_val({tag, "_vld"}, 32'(rvalid), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: read with empty scoreboard, rdata %0h", tag, rdata);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, 32'(rdata), 32'(e));
      if (in_win) hist.push_back(e);
    end
    rinc = 1'b1;
    tick();
  endtask

  task automatic requeue(input bit last);
    if (!last)
      for (int i = hist.size() - 1; i >= 0; i--) exp_q.push_front(hist[i]);
    else
      in_win = 1'b0;
    hist.delete();
  endtask

  task automatic do_replay(input bit last);
    replay = 1'b1;
    requeue(last);
    tick();
  endtask

  task automatic open_win(input logic [CW-1:0] iters);
    win_open = 1'b1; win_iters = iters;
    in_win = 1'b1; hist.delete();
    tick();
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_wfull"},  32'(wfull), 0);
    check_val({tag, "_rvalid"}, 32'(rvalid), 0);
    check_val({tag, "_inwin"},  32'(in_window), 0);
    check_val({tag, "_iter"},   32'(replay_iter), 0);
    check_val({tag, "_done"},   32'(replay_done), 0);
    check_val({tag, "_count"},  32'(count), 0);
    check_val({tag, "_err"},    32'(window_err), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    check_zero(tag);
    reset = 1'b0;
    exp_q.delete(); hist.delete(); in_win = 1'b0;
  endtask

  initial begin
    reset = 1'b1; winc = 1'b0; rinc = 1'b0; win_open = 1'b0; replay = 1'b0;
    wdata = '0; win_iters = '0;
    tick(); tick();
    check_zero("por");
    reset = 1'b0;

    // Basic FIFO fill, drop on full, drain in order
    push_wr(16'hA, 1); push_wr(16'hB, 1); push_wr(16'hC, 1); push_wr(16'hD, 1);
    check_val("fill_wfull", 32'(wfull), 1);
    check_val("fill_count", 32'(count), 4);
    push_wr(16'hE, 0);
    check_val("drop_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) pop_rd("basic_rd");
    check_val("drain_rvalid", 32'(rvalid), 0);
    check_val("drain_count", 32'(count), 0);

    // Three-iteration replay
    push_wr(16'h11, 1); push_wr(16'h22, 1); push_wr(16'h33, 1);
    open_win(4'd3);
    check_val("r3_inwin", 32'(in_window), 1);
    for (int i = 0; i < 3; i++) pop_rd("r3_it0");
    do_replay(0);
    check_val("r3_iter1", 32'(replay_iter), 1);
    check_val("r3_rdata1", 32'(rdata), 32'h11);
    for (int i = 0; i < 3; i++) pop_rd("r3_it1");
    do_replay(0);
    check_val("r3_iter2", 32'(replay_iter), 2);
    for (int i = 0; i < 3; i++) pop_rd("r3_it2");
    do_replay(1);
    check_val("r3_done", 32'(replay_done), 1);
    check_val("r3_inwin_off", 32'(in_window), 0);
    check_val("r3_count", 32'(count), 0);
    check_val("r3_iter_clr", 32'(replay_iter), 0);
    tick();
    check_val("r3_done_pulse", 32'(replay_done), 0);

    // Retention keeps slots held until commit; full+empty window flags deadlock
    open_win(4'd1);
    for (int i = 0; i < 4; i++) push_wr(16'h41 + 16'(i), 1);
    for (int i = 0; i < 4; i++) pop_rd("ret_rd");
    check_val("ret_wfull", 32'(wfull), 1);
    check_val("ret_rvalid", 32'(rvalid), 0);
    push_wr(16'h99, 0);
    check_val("ret_wfull_hold", 32'(wfull), 1);
    check_val("ret_count_hold", 32'(count), 4);
    check_val("ret_deadlock_err", 32'(window_err), 1);
    do_replay(1);
    check_val("ret_done", 32'(replay_done), 1);
    check_val("ret_free", 32'(wfull), 0);
    check_val("ret_count0", 32'(count), 0);
    push_wr(16'h55, 1);
    check_val("ret_post_wr", 32'(count), 1);
    pop_rd("ret_post_rd");
    do_reset("rst1");

    // replay + rinc + winc together
    push_wr(16'h1, 1); push_wr(16'h2, 1); push_wr(16'h3, 1);
    open_win(4'd2);
    pop_rd("sim_rd");
    rinc = 1'b1; replay = 1'b1; winc = 1'b1; wdata = 16'h4;
    requeue(0);
    exp_q.push_back(16'h4);
    tick();
    check_val("sim_iter", 32'(replay_iter), 1);
    check_val("sim_rdata", 32'(rdata), 32'h1);
    check_val("sim_count", 32'(count), 4);
    for (int i = 0; i < 3; i++) pop_rd("sim_it1");
    do_replay(1);
    check_val("sim_done", 32'(replay_done), 1);
    check_val("sim_count_commit", 32'(count), 1);
    pop_rd("sim_tail");
    check_val("sim_empty", 32'(count), 0);

    // Protocol errors
    do_reset("rst2");
    push_wr(16'h7, 1);
    replay = 1'b1;
    tick();
    check_val("err_idle_replay", 32'(window_err), 1);
    check_val("err_count", 32'(count), 1);
    check_val("err_rdata", 32'(rdata), 32'h7);
    check_val("err_inwin", 32'(in_window), 0);
    do_reset("rst3");
    push_wr(16'h8, 1);
    open_win(4'd0);
    win_open = 1'b1;
    tick();
    check_val("err_dbl_open", 32'(window_err), 1);
    check_val("err_win_cont", 32'(in_window), 1);
    pop_rd("err_rd");
    do_replay(1);
    check_val("err_iters0_done", 32'(replay_done), 1);

    // Window across pointer wrap, then reset mid second iteration
    do_reset("rst4");
    for (int i = 0; i < 3; i++) begin
      push_wr(16'h100 + 16'(i), 1);
      pop_rd("wrap_pre");
    end
    open_win(4'd2);
    for (int i = 0; i < 3; i++) push_wr(16'h200 + 16'(i), 1);
    for (int i = 0; i < 3; i++) pop_rd("wrap_it0");
    do_replay(0);
    check_val("wrap_iter1", 32'(replay_iter), 1);
    check_val("wrap_count", 32'(count), 3);
    pop_rd("wrap_it1");
    pop_rd("wrap_it1");
    do_reset("wrap_rst");
    for (int i = 0; i < 4; i++) begin
      push_wr(16'h300 + 16'(i), 1);
      pop_rd("wrap_post");
    end
    check_val("wrap_final_count", 32'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
